mano_mem_wr: RTL and testbench

- Memory unit and write-back path of the basic computer: a 4096x16 word array with combinational read onto the bus, plus a posted write buffer.
- DR, IR and AR load from its read port at their timing slots.
- This block is the writer side. It decodes IR and the timing count, then commits memory-reference stores from AC, PC or DR into M[AR].

---
 rtl/mano_mem_wr_if.sv | 25 ++
 rtl/mano_mem_wr.sv | 108 ++++++++++
 tb/tb_mano_mem_wr.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mano_mem_wr_if.sv
// Bus bundle between the basic-computer datapath (master) and the memory write-back unit (slave).
interface mano_mem_wr_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] IN_IR;
  logic [2:0]        t;
  logic [ADDR_W-1:0] IN_AR;
  logic [DATA_W-1:0] IN_AC;
  logic [ADDR_W-1:0] IN_PC;
  logic [DATA_W-1:0] IN_DR;
  logic [DATA_W-1:0] Q_MEM;
  logic              WR_PEND;
  logic              WR_DONE;

  modport master (
    output IN_IR, t, IN_AR, IN_AC, IN_PC, IN_DR,
    input  Q_MEM, WR_PEND, WR_DONE
  );

  modport slave (
    input  IN_IR, t, IN_AR, IN_AC, IN_PC, IN_DR,
    output Q_MEM, WR_PEND, WR_DONE
  );
endinterface

// File: rtl/mano_mem_wr.sv
// Basic-computer memory with combinational read and a one-entry posted write buffer for STA/BSA/ISZ.
// Define MEM_FWD_EN to forward the pending buffer entry onto Q_MEM for a same-address read.
module mano_mem_wr #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4096  // must equal 2**ADDR_W
) (
  input  logic           CLK,
  input  logic           RST,
  mano_mem_wr_if.slave   bus
);

  typedef enum logic {IDLE, PEND} state_t;

  localparam logic [2:0] OP_STA = 3'b011;
  localparam logic [2:0] OP_BSA = 3'b101;
  localparam logic [2:0] OP_ISZ = 3'b110;
  localparam logic [2:0] OP_REG = 3'b111;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_data;
  logic              wr_pend;
  logic              wr_done;

  logic              req;
  logic [DATA_W-1:0] req_data;
  logic [2:0]        opcode;

  // I bit and the address field are not needed: indirection is already resolved into AR.
  logic unused_ir_bits;
  assign unused_ir_bits = ^{bus.IN_IR[DATA_W-1], bus.IN_IR[DATA_W-5:0]};

  assign opcode = bus.IN_IR[DATA_W-2 -: 3];

  // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
  always_comb begin
    req      = 1'b0;
    req_data = '0;
    if (opcode != OP_REG) begin
      unique case (opcode)
        OP_STA: if (bus.t == 3'd4) begin
          req      = 1'b1;
          req_data = bus.IN_AC;
        end
        OP_BSA: if (bus.t == 3'd4) begin
          req      = 1'b1;
          req_data = {{(DATA_W-ADDR_W){1'b0}}, bus.IN_PC};
        end
        OP_ISZ: if (bus.t == 3'd6) begin
          req      = 1'b1;
          req_data = bus.IN_DR;
        end
        default: ;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      buf_addr <= '0;
      buf_data <= '0;
      wr_pend  <= 1'b0;
      wr_done  <= 1'b0;
    end else begin
      wr_done <= (state == PEND);
      if (req) begin
        buf_addr <= bus.IN_AR;
        buf_data <= req_data;
      end
      unique case (state)
        IDLE: if (req) begin
          state   <= PEND;
          wr_pend <= 1'b1;
        end
        PEND: begin
          state   <= req ? PEND : IDLE;
          wr_pend <= req;
        end
        default: begin
          state   <= IDLE;
          wr_pend <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: the array has no reset; RST only blocks the commit so a pending write is dropped.
  always_ff @(posedge CLK) begin
    if (!RST && state == PEND) begin
      mem[buf_addr] <= buf_data;
    end
  end

`ifdef MEM_FWD_EN
  assign bus.Q_MEM = (wr_pend && bus.IN_AR == buf_addr) ? buf_data : mem[bus.IN_AR];
`else
  assign bus.Q_MEM = mem[bus.IN_AR];
`endif

  assign bus.WR_PEND = wr_pend;
  assign bus.WR_DONE = wr_done;

endmodule

// File: tb/tb_mano_mem_wr.sv
// Scoreboard bench for mano_mem_wr: directed test-plan sequences followed by random instruction traffic.
module tb_mano_mem_wr;

  logic CLK;
  logic RST;

  mano_mem_wr_if #(.ADDR_W(12), .DATA_W(16)) bus ();

  mano_mem_wr #(.ADDR_W(12), .DATA_W(16), .DEPTH(4096)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int          cyc;
    logic        pend;
    logic        done;
    bit          q_chk;
    logic [15:0] q;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Reference model: architectural memory contents plus the one write that is still in flight.
  logic [15:0] m_mem [int unsigned];
  bit          p_valid;
  logic [11:0] p_addr;
  logic [15:0] p_data;
  bit          m_done;

  task automatic check(input string name, input int c, input logic [15:0] act, input logic [15:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, c, act, expv);
    end
  endtask

  // Memory-reference store rules of the basic computer.
  function automatic bit store_req(input logic [15:0] ir, input logic [2:0] tt,
                                   input logic [15:0] ac, input logic [11:0] pc,
                                   input logic [15:0] dr, output logic [15:0] d);
    int op = int'(ir[14:12]);
    d = 16'h0;
    if (op == 3 && tt == 3'd4) begin d = ac;               return 1; end
    if (op == 5 && tt == 3'd4) begin d = 16'(pc);          return 1; end
    if (op == 6 && tt == 3'd6) begin d = dr;               return 1; end
    return 0;
  endfunction

  task automatic drive(input bit rst, input logic [15:0] ir, input logic [2:0] tt,
                       input logic [11:0] ar, input logic [15:0] ac,
                       input logic [11:0] pc, input logic [15:0] dr);
    exp_t        e;
    logic [15:0] d;
    bit          rq;
    RST = rst; bus.IN_IR = ir; bus.t = tt; bus.IN_AR = ar;
    bus.IN_AC = ac; bus.IN_PC = pc; bus.IN_DR = dr;
    e.cyc  = cyc;
    e.pend = p_valid;
    e.done = m_done;
    e.q_chk = 1'b0;
    e.q     = 16'h0;
`ifdef MEM_FWD_EN
    if (p_valid && p_addr == ar) begin
      e.q_chk = 1'b1; e.q = p_data;
    end else
`endif
    if (m_mem.exists(int'(ar))) begin
      e.q_chk = 1'b1; e.q = m_mem[int'(ar)];
    end
    exp_q.push_back(e);
    rq = store_req(ir, tt, ac, pc, dr, d);
    @(posedge CLK);
    if (rst) begin
      p_valid = 0;
      m_done  = 0;
    end else begin
      m_done = p_valid;
      if (p_valid) m_mem[int'(p_addr)] = p_data;
      p_valid = rq;
      if (rq) begin p_addr = ar; p_data = d; end
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input logic [11:0] ar);
    drive(0, 16'h0000, 3'd0, ar, 16'h0, 12'h0, 16'h0);
  endtask

  // Monitor: compares the DUT against the next expected entry in mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_pend", e.cyc, 16'(bus.WR_PEND), 16'(e.pend));
        check("wr_done", e.cyc, 16'(bus.WR_DONE), 16'(e.done));
        if (e.q_chk) check("q_mem", e.cyc, bus.Q_MEM, e.q);
      end
    end
  end

  initial begin
    logic [2:0]  op;
    logic [11:0] ar;
    logic [2:0]  tt;
    p_valid = 0; m_done = 0; p_addr = '0; p_data = '0;
    RST = 1'b1; bus.IN_IR = '0; bus.t = '0; bus.IN_AR = '0;
    bus.IN_AC = '0; bus.IN_PC = '0; bus.IN_DR = '0;
    @(posedge CLK);
    #1;

    // Preload 0x010 with 0xAAAA, then a reset edge coinciding with an STA request.
    drive(0, 16'h3010, 3'd4, 12'h010, 16'hAAAA, 12'h0, 16'h0);
    drive(0, 16'h3010, 3'd5, 12'h010, 16'hAAAA, 12'h0, 16'h0);
    idle(12'h010);
    drive(1, 16'h3010, 3'd4, 12'h010, 16'h1234, 12'h0, 16'h0);
    idle(12'h010);
    idle(12'h010);

    // STA, BSA, ISZ commits and read-back.
    drive(0, 16'h3010, 3'd4, 12'h010, 16'h1234, 12'h0, 16'h0);
    drive(0, 16'h3010, 3'd5, 12'h010, 16'h1234, 12'h0, 16'h0);
    idle(12'h010);
    drive(0, 16'h5020, 3'd4, 12'h020, 16'h0, 12'hABC, 16'h0);
    idle(12'h000);
    idle(12'h020);
    drive(0, 16'h6030, 3'd6, 12'h030, 16'hFFFF, 12'h0, 16'h0000);
    idle(12'h000);
    idle(12'h030);
    drive(0, 16'h6030, 3'd4, 12'h030, 16'h0, 12'h0, 16'h5555);
    drive(0, 16'h6030, 3'd5, 12'h030, 16'h0, 12'h0, 16'h5555);
    drive(0, 16'h7800, 3'd4, 12'h030, 16'h7777, 12'h0, 16'h0);
    drive(0, 16'h1010, 3'd4, 12'h030, 16'h7777, 12'h0, 16'h0);
    idle(12'h030);

    // Address boundaries 0x000 and 0xFFF, back-to-back to keep the buffer busy.
    drive(0, 16'hB000, 3'd4, 12'h000, 16'h0F0F, 12'h0, 16'h0);
    drive(0, 16'h3FFF, 3'd4, 12'hFFF, 16'hF0F0, 12'h0, 16'h0);
    idle(12'h000);
    idle(12'hFFF);

    // Forwarding: same-address read in the pending cycle, then one cycle later.
    drive(0, 16'h3040, 3'd4, 12'h040, 16'h5678, 12'h0, 16'h0);
    idle(12'h040);
    idle(12'h040);

    // Reset mid-operation discards the captured write.
    drive(0, 16'h3050, 3'd4, 12'h050, 16'h1111, 12'h0, 16'h0);
    idle(12'h050);
    idle(12'h050);
    drive(0, 16'h3050, 3'd4, 12'h050, 16'h9999, 12'h0, 16'h0);
    drive(1, 16'h0000, 3'd0, 12'h050, 16'h0, 12'h0, 16'h0);
    idle(12'h050);
    idle(12'h050);

    // Stalled sequence counter: repeated requests give repeated WR_DONE pulses.
    repeat (4) drive(0, 16'h3060, 3'd4, 12'h060, 16'hCAFE, 12'h0, 16'h0);
    idle(12'h060);
    idle(12'h060);

    // Random traffic over a small address pool to provoke same-address hazards.
    for (int i = 0; i < 400; i++) begin
      op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) op = ($urandom_range(0, 2) == 0) ? 3'b011 :
                                          ($urandom_range(0, 1) == 0) ? 3'b101 : 3'b110;
      tt = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(0, 7))
                                       : ((op == 3'b110) ? 3'd6 : 3'd4);
      case ($urandom_range(0, 4))
        0: ar = 12'h000;
        1: ar = 12'hFFF;
        2: ar = 12'h010;
        3: ar = 12'h011;
        default: ar = 12'($urandom_range(0, 4095));
      endcase
      drive(($urandom_range(0, 39) == 0),
            {1'($urandom_range(0, 1)), op, 12'($urandom_range(0, 4095))},
            tt, ar, 16'($urandom), 12'($urandom), 16'($urandom));
    end
    idle(12'h010);
    idle(12'h011);

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge CLK);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain remaining=%0d expected=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
